// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory: port 0 issues
// single-word CPU accesses, port 1 issues uninterruptible incrementing bursts.
module dmem_arbiter #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic             m0_ack,
    output logic [31:0]      m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [LEN_W-1:0] m1_len,
    input  logic [31:0]      m1_wdata,
    output logic             m1_beat,
    output logic             m1_ack,
    output logic [31:0]      m1_rdata,
    output logic             m1_done,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        BURST1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               we0_q, we0_d;
    logic [31:0]        addr0_q, addr0_d;
    logic [31:0]        wdata0_q, wdata0_d;
    logic               we1_q, we1_d;
    logic [31:0]        baddr_q, baddr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               m0_ack_q, m0_ack_d;
    logic [31:0]        m0_rdata_q, m0_rdata_d;
    logic               m1_ack_q, m1_ack_d;
    logic [31:0]        m1_rdata_q, m1_rdata_d;
    logic               m1_done_q, m1_done_d;

    logic               elig0, elig1;
    logic               grant0, grant1;

    assign m0_ack   = m0_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_ack   = m1_ack_q;
    assign m1_rdata = m1_rdata_q;
    assign m1_done  = m1_done_q;

    // A requester whose ack is still high is skipped for one cycle so a
    // level request held across completion is not mistaken for a new one.
    assign elig0  = m0_req & ~m0_ack_q;
    assign elig1  = m1_req & ~m1_ack_q;
    assign grant0 = elig0 & (~elig1 | last_q);
    assign grant1 = elig1 & (~elig0 | ~last_q);

    // Memory-side drive; strobes are gated by rst_n so no access escapes
    // while reset is asserted, even mid-operation.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        m1_beat   = 1'b0;
        case (state_q)
            SERVE0: begin
                mem_read  = ~we0_q & rst_n;
                mem_write = we0_q & rst_n;
                mem_addr  = addr0_q;
                mem_wdata = wdata0_q;
            end
            BURST1: begin
                m1_beat   = 1'b1;
                mem_read  = ~we1_q & rst_n;
                mem_write = we1_q & rst_n;
                mem_addr  = baddr_q;
                mem_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        we0_d      = we0_q;
        addr0_d    = addr0_q;
        wdata0_d   = wdata0_q;
        we1_d      = we1_q;
        baddr_d    = baddr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        m0_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_ack_d   = 1'b0;
        m1_rdata_d = m1_rdata_q;
        m1_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    state_d  = SERVE0;
                    we0_d    = m0_we;
                    addr0_d  = m0_addr;
                    wdata0_d = m0_wdata;
                end else if (grant1) begin
                    state_d = BURST1;
                    we1_d   = m1_we;
                    baddr_d = m1_addr;
                    len_d   = m1_len;
                    cnt_d   = '0;
                end
            end
            SERVE0: begin
                m0_ack_d = 1'b1;
                if (!we0_q) begin
                    m0_rdata_d = mem_rdata;
                end
                last_d  = 1'b0;
                state_d = IDLE;
            end
            BURST1: begin
                m1_ack_d = 1'b1;
                if (!we1_q) begin
                    m1_rdata_d = mem_rdata;
                end
                baddr_d = baddr_q + 32'd4;
                cnt_d   = cnt_q + LEN_W'(1);
                if (cnt_q == len_q) begin
                    m1_done_d = 1'b1;
                    last_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            we0_q      <= 1'b0;
            addr0_q    <= '0;
            wdata0_q   <= '0;
            we1_q      <= 1'b0;
            baddr_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            m0_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_ack_q   <= 1'b0;
            m1_rdata_q <= '0;
            m1_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            we0_q      <= we0_d;
            addr0_q    <= addr0_d;
            wdata0_q   <= wdata0_d;
            we1_q      <= we1_d;
            baddr_q    <= baddr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            m0_ack_q   <= m0_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_ack_q   <= m1_ack_d;
            m1_rdata_q <= m1_rdata_d;
            m1_done_q  <= m1_done_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-word behavioural DataMemory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr;
    logic [3:0]  m1_len;
    logic [31:0] m1_wdata;
    logic        m1_beat, m1_ack, m1_done;
    logic [31:0] m1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    int          n_cmp = 0;
    int          n_err = 0;
    int          bad_wr = 0;

    dmem_arbiter #(.LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_len(m1_len),
        .m1_wdata(m1_wdata), .m1_beat(m1_beat), .m1_ack(m1_ack),
        .m1_rdata(m1_rdata), .m1_done(m1_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
        if (!rst_n && mem_write) bad_wr++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    logic [31:0] alt_beat [7];
    logic [31:0] alt_rd   [7];
    logic [31:0] alt_addr [7];
    logic [31:0] wr_data  [3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        alt_beat = '{0, 0, 1, 0, 0, 0, 1};
        alt_rd   = '{1, 0, 1, 0, 1, 0, 1};
        alt_addr = '{0, 0, 4, 0, 0, 0, 4};
        wr_data  = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};

        // Reset held two cycles with both requests high.
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h1234_5678;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4; m1_len = 4'd0; m1_wdata = 32'h5555_5555;
        tick();
        tick();
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m1_done", m1_done, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_m1_beat", m1_beat, 0);

        // Both ports contend continuously: m0, m1, m0, m1.
        rst_n = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("alt_beat_%0d", i), m1_beat, alt_beat[i]);
            chk($sformatf("alt_rd_%0d", i), mem_read, alt_rd[i]);
            chk($sformatf("alt_addr_%0d", i), mem_addr, alt_addr[i]);
            chk($sformatf("alt_m0ack_%0d", i), m0_ack, (i == 1 || i == 5) ? 1 : 0);
            chk($sformatf("alt_m1ack_%0d", i), m1_ack, (i == 3) ? 1 : 0);
            if (i == 6) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            tick();
        end

        // m0 single write then read back.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
        tick();
        m0_req = 1'b0; m0_addr = 32'h99; m0_wdata = 32'h0;
        #1;
        chk("w0_mem_write", mem_write, 1);
        chk("w0_mem_addr", mem_addr, 32'h10);
        chk("w0_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("w0_ack_early", m0_ack, 0);
        tick();
        chk("w0_ack", m0_ack, 1);
        chk("w0_write_done", mem_write, 0);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        tick();
        chk("r0_ignored_ack", m0_ack, 0);
        chk("r0_ignored_read", mem_read, 0);
        tick();
        chk("r0_mem_read", mem_read, 1);
        chk("r0_mem_addr", mem_addr, 32'h10);
        m0_req = 1'b0;
        tick();
        chk("r0_ack", m0_ack, 1);
        chk("r0_rdata", m0_rdata, 32'hDEAD_BEEF);

        // m1 read burst len=3 from 0x20, m0 request arrives during beat 1.
        mem[8] = 32'd1; mem[9] = 32'd2; mem[10] = 32'd3; mem[11] = 32'd4;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_len = 4'd3;
        tick();
        m1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rb_beat_%0d", i), m1_beat, 1);
            chk($sformatf("rb_addr_%0d", i), mem_addr, 32'h20 + 32'(4 * i));
            chk($sformatf("rb_ack_%0d", i), m1_ack, (i > 0) ? 1 : 0);
            if (i > 0) chk($sformatf("rb_rdata_%0d", i), m1_rdata, 32'(i));
            chk($sformatf("rb_done_%0d", i), m1_done, 0);
            if (i == 1) begin
                m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
            end
            tick();
        end
        chk("rb_last_ack", m1_ack, 1);
        chk("rb_last_rdata", m1_rdata, 32'd4);
        chk("rb_done", m1_done, 1);
        chk("rb_idle_beat", m1_beat, 0);
        tick();
        chk("rb_m0_grant_read", mem_read, 1);
        chk("rb_m0_grant_addr", mem_addr, 32'h20);
        chk("rb_m0_grant_beat", m1_beat, 0);
        m0_req = 1'b0;
        tick();
        chk("rb_m0_ack", m0_ack, 1);
        chk("rb_m0_rdata", m0_rdata, 32'd1);

        // m1 write burst len=2 wrapping past the top of the address space.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hFFFF_FFF8; m1_len = 4'd2;
        m1_wdata = wr_data[0];
        tick();
        m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m1_wdata = wr_data[i];
            #1;
            chk($sformatf("wb_write_%0d", i), mem_write, 1);
            chk($sformatf("wb_addr_%0d", i), mem_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            chk($sformatf("wb_wdata_%0d", i), mem_wdata, wr_data[i]);
            tick();
        end
        chk("wb_done", m1_done, 1);
        tick();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hFFFF_FFF8; m1_len = 4'd2;
        tick();
        m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wr_addr_%0d", i), mem_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            if (i > 0) chk($sformatf("wr_rdata_%0d", i - 1), m1_rdata, wr_data[i - 1]);
            tick();
        end
        chk("wr_rdata_2", m1_rdata, wr_data[2]);
        chk("wr_done", m1_done, 1);

        // Reset asserted during beat 2 of a len=3 write burst at 0x40.
        tick();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_len = 4'd3;
        m1_wdata = 32'h11;
        tick();
        m1_req = 1'b0;
        chk("rs_beat0_write", mem_write, 1);
        chk("rs_beat0_addr", mem_addr, 32'h40);
        tick();
        m1_wdata = 32'h22;
        #1;
        chk("rs_beat1_addr", mem_addr, 32'h44);
        tick();
        m1_wdata = 32'h33; rst_n = 1'b0;
        #1;
        chk("rs_beat2_write", mem_write, 0);
        chk("rs_beat2_read", mem_read, 0);
        tick();
        rst_n = 1'b1;
        chk("rs_ack", m1_ack, 0);
        chk("rs_done", m1_done, 0);
        chk("rs_idle_beat", m1_beat, 0);
        chk("rs_idle_write", mem_write, 0);
        tick();
        chk("rs_ack2", m1_ack, 0);
        chk("rs_done2", m1_done, 0);
        chk("rs_beat2", m1_beat, 0);
        chk("rs_mem40", mem[16], 32'h11);
        chk("rs_mem44", mem[17], 32'h22);
        chk("rs_mem48", mem[18], 32'h0);
        chk("rs_mem4c", mem[19], 32'h0);
        chk("rst_no_write", 32'(bad_wr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
